conv_window_gen: RTL and testbench

Streaming sliding-window generator that feeds the convolution unit's per-window feature input.
- Accepts a raster-order pixel stream, one pixel per cycle, through a valid/ready handshake.
- Buffers KERNEL_DIM-1 image rows internally.
- Emits each KERNEL_DIM x KERNEL_DIM window as a flat row-major vector, index ordering identical to the kernel vectors, with a valid/ready handshake.
- Covers valid (unpadded) convolution, stride 1, one frame per start command.

---
 rtl/conv_window_gen_if.sv | 30 +++
 rtl/conv_window_gen.sv | 112 +++++++++++
 tb/tb_conv_window_gen.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/conv_window_gen_if.sv
// Handshake bundle between a pixel source / window sink and conv_window_gen.
//   i_start                  frame start command
//   i_pixel / i_pixel_valid  raster pixel stream in, o_pixel_ready back-pressure
//   o_window / o_window_valid  flat row-major window out, i_window_ready back-pressure
//   o_busy / o_done          frame status
// master: the window generator.  slave: the host driving pixels and taking windows.
interface conv_window_gen_if #(
  parameter int DATA_WIDTH = 32,
  parameter int CONV_SIZE  = 9
);
  logic                                 i_start;
  logic [DATA_WIDTH-1:0]                i_pixel;
  logic                                 i_pixel_valid;
  logic                                 o_pixel_ready;
  logic [CONV_SIZE-1:0][DATA_WIDTH-1:0] o_window;
  logic                                 o_window_valid;
  logic                                 i_window_ready;
  logic                                 o_busy;
  logic                                 o_done;

  modport master (
    input  i_start, i_pixel, i_pixel_valid, i_window_ready,
    output o_pixel_ready, o_window, o_window_valid, o_busy, o_done
  );

  modport slave (
    output i_start, i_pixel, i_pixel_valid, i_window_ready,
    input  o_pixel_ready, o_window, o_window_valid, o_busy, o_done
  );
endinterface

// File: rtl/conv_window_gen.sv
// Streaming sliding-window generator (valid convolution, stride 1).
// Takes a raster pixel stream, keeps KERNEL_DIM-1 rows in line buffers and emits
// every KERNEL_DIM x KERNEL_DIM window as a flat vector, index r*KERNEL_DIM+c,
// r=0 the oldest row, c=0 the leftmost column.
// Ports:
//   i_clock  clock
//   i_reset  synchronous active-low reset
//   bus      conv_window_gen_if master: start, pixel stream, window stream, busy/done
module conv_window_gen #(
  parameter int DATA_WIDTH = 32,
  parameter int KERNEL_DIM = 3,
  parameter int IMG_WIDTH  = 28,
  parameter int IMG_HEIGHT = 28
) (
  input  logic              i_clock,
  input  logic              i_reset,
  conv_window_gen_if.master bus
);
  localparam int CONV_SIZE = KERNEL_DIM * KERNEL_DIM;
  localparam int COL_W     = $clog2(IMG_WIDTH);
  localparam int ROW_W     = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_K    = COL_W'(KERNEL_DIM - 1);
  localparam logic [ROW_W-1:0] ROW_K    = ROW_W'(KERNEL_DIM - 1);

  typedef enum logic [2:0] {IDLE, FILL, STREAM, DRAIN, DONE} state_t;
  state_t state, state_nxt;

  logic [ROW_W-1:0]                      row;
  logic [COL_W-1:0]                      col;
  logic [CONV_SIZE-1:0][DATA_WIDTH-1:0]  win;
  logic                                  win_vld;
  // line_buf[col][0] is the oldest buffered row at that column
  logic [KERNEL_DIM-2:0][DATA_WIDTH-1:0] line_buf [IMG_WIDTH];
  logic [KERNEL_DIM-1:0][DATA_WIDTH-1:0] new_col;
  logic                                  pix_rdy, accept, win_hs, win_cmpl, last_pix;

  // A stalled window blocks pixel intake so the held window cannot be overwritten.
  assign pix_rdy  = (state == FILL || state == STREAM) && !(win_vld && !bus.i_window_ready);
  assign accept   = bus.i_pixel_valid && pix_rdy;
  assign win_hs   = win_vld && bus.i_window_ready;
  // Windows straddling a row boundary are built anyway; this mask drops them.
  assign win_cmpl = (row >= ROW_K) && (col >= COL_K);
  assign last_pix = (row == ROW_LAST) && (col == COL_LAST);

  assign bus.o_pixel_ready  = pix_rdy;
  assign bus.o_window       = win;
  assign bus.o_window_valid = win_vld;
  assign bus.o_busy         = (state == FILL) || (state == STREAM) || (state == DRAIN);
  assign bus.o_done         = (state == DONE);

  always_comb begin
    new_col = '0;
    for (int k = 0; k < KERNEL_DIM - 1; k++) new_col[k] = line_buf[col][k];
    new_col[KERNEL_DIM-1] = bus.i_pixel;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:   if (bus.i_start) state_nxt = FILL;
      // A frame exactly KERNEL_DIM wide/high completes its only window on the last pixel.
      FILL:   if (accept && last_pix) state_nxt = DRAIN;
              else if (accept && win_cmpl) state_nxt = STREAM;
      STREAM: if (accept && last_pix) state_nxt = DRAIN;
      // The last pixel always completes a window, so the one pending here is the final one.
      DRAIN:  if (win_hs) state_nxt = DONE;
      DONE:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (!i_reset) begin
      state   <= IDLE;
      row     <= '0;
      col     <= '0;
      win     <= '0;
      win_vld <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.i_start) begin
        row <= '0;
        col <= '0;
      end
      if (accept) begin
        for (int r = 0; r < KERNEL_DIM; r++) begin
          for (int c = 0; c < KERNEL_DIM - 1; c++)
            win[r*KERNEL_DIM+c] <= win[r*KERNEL_DIM+c+1];
          win[r*KERNEL_DIM+KERNEL_DIM-1] <= new_col[r];
        end
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      if (accept && win_cmpl) win_vld <= 1'b1;
      else if (win_hs)        win_vld <= 1'b0;
    end
  end

  // Each column slot shifts up by one row; the new pixel becomes the newest row.
  always_ff @(posedge i_clock) begin
    if (accept) begin
      for (int k = 0; k < KERNEL_DIM - 2; k++) line_buf[col][k] <= line_buf[col][k+1];
      line_buf[col][KERNEL_DIM-2] <= bus.i_pixel;
    end
  end
endmodule

// File: tb/tb_conv_window_gen.sv
module tb_conv_window_gen;
  typedef logic [8:0][31:0] win_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;
  int fails  = 0;
  logic [31:0] small_pix[$];

  conv_window_gen_if #(.DATA_WIDTH(32), .CONV_SIZE(9)) s_if ();
  conv_window_gen_if #(.DATA_WIDTH(32), .CONV_SIZE(9)) b_if ();

  conv_window_gen #(.DATA_WIDTH(32), .KERNEL_DIM(3), .IMG_WIDTH(5), .IMG_HEIGHT(4)) u_small (
    .i_clock(clk), .i_reset(rst_n), .bus(s_if)
  );
  conv_window_gen #(.DATA_WIDTH(32), .KERNEL_DIM(3), .IMG_WIDTH(28), .IMG_HEIGHT(28)) u_big (
    .i_clock(clk), .i_reset(rst_n), .bus(b_if)
  );

  task automatic chk(input string tag, input logic [287:0] obs, input logic [287:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Window wi of a frame w pixels wide, windows numbered in raster order of their top-left corner.
  function automatic win_t model_win(input logic [31:0] pix[$], input int w, input int wi);
    int   nw = w - 2;
    int   wr = wi / nw;
    int   wc = wi % nw;
    win_t res;
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 3; c++)
        res[r*3+c] = pix[(wr + r) * w + wc + c];
    return res;
  endfunction

  task automatic run_small(input string nm, input bit tog, input bit stall,
                           input bit start_mid, input bit do_rst);
    win_t got[$];
    int idx = 0, cyc = 0, stall_left = stall ? 3 : 0;
    int acc12 = -1, first_v = -1, last_hs = -1, done_cyc = -1, done_n = 0;
    bit fin = 0;
    s_if.i_pixel_valid  = 1'b0;
    s_if.i_window_ready = 1'b1;
    s_if.i_start        = 1'b1;
    @(posedge clk); #1;
    s_if.i_start = 1'b0;
    while (!fin && cyc < 200) begin
      s_if.i_pixel_valid = (idx < 20) && (!tog || (cyc % 2 == 0));
      s_if.i_pixel       = (idx < 20) ? small_pix[idx] : 32'd0;
      s_if.i_start       = start_mid && (idx == 15);
      if (stall && s_if.o_window_valid && stall_left > 0) begin
        s_if.i_window_ready = 1'b0;
        stall_left--;
      end else s_if.i_window_ready = 1'b1;
      @(negedge clk);
      if (!s_if.i_window_ready) begin
        chk({nm, " stall window"}, s_if.o_window, model_win(small_pix, 5, 0));
        chk({nm, " stall pixel_ready"}, s_if.o_pixel_ready, 0);
      end
      if (s_if.i_start) chk({nm, " start ignored busy"}, s_if.o_busy, 1);
      if (s_if.o_window_valid && first_v < 0) first_v = cyc;
      if (s_if.o_done) begin done_n++; done_cyc = cyc; end
      if (s_if.o_window_valid && s_if.i_window_ready) begin
        got.push_back(s_if.o_window);
        last_hs = cyc;
      end
      if (s_if.i_pixel_valid && s_if.o_pixel_ready) begin
        if (idx == 12) acc12 = cyc;
        idx++;
      end
      if (do_rst && idx == 14) begin
        // pixel 13 is accepted on the coming edge; reset is applied on the one after
        @(posedge clk); #1;
        rst_n = 1'b0;
        s_if.i_pixel_valid = 1'b0;
        @(posedge clk); #1;
        chk({nm, " rst window_valid"}, s_if.o_window_valid, 0);
        chk({nm, " rst busy"}, s_if.o_busy, 0);
        chk({nm, " rst window"}, s_if.o_window, '0);
        chk({nm, " rst done"}, s_if.o_done, 0);
        rst_n = 1'b1;
        s_if.i_pixel_valid = 1'b1;
        repeat (3) begin
          @(negedge clk);
          chk({nm, " post-rst pixel_ready"}, s_if.o_pixel_ready, 0);
          chk({nm, " post-rst window_valid"}, s_if.o_window_valid, 0);
        end
        @(posedge clk); #1;
        s_if.i_pixel_valid = 1'b0;
        return;
      end
      fin = (done_n > 0) && (cyc >= done_cyc + 3);
      @(posedge clk); #1;
      cyc++;
    end
    s_if.i_start = 1'b0;
    chk({nm, " finished in budget"}, fin, 1);
    chk({nm, " window count"}, got.size(), 6);
    for (int i = 0; i < got.size() && i < 6; i++)
      chk($sformatf("%s window %0d", nm, i), got[i], model_win(small_pix, 5, i));
    chk({nm, " first window latency"}, first_v, acc12 + 1);
    chk({nm, " done pulses"}, done_n, 1);
    chk({nm, " done after last handshake"}, done_cyc, last_hs + 1);
  endtask

  task automatic run_big();
    logic [31:0] pix[$];
    win_t got[$];
    win_t held = '0;
    bit   hold = 0;
    int   idx = 0, cyc = 0, done_n = 0;
    for (int i = 0; i < 784; i++) pix.push_back($urandom);
    b_if.i_pixel_valid  = 1'b0;
    b_if.i_window_ready = 1'b1;
    b_if.i_start        = 1'b1;
    @(posedge clk); #1;
    b_if.i_start = 1'b0;
    while (done_n == 0 && cyc < 20000) begin
      b_if.i_pixel_valid  = (idx < 784) && ($urandom_range(0, 3) != 0);
      if (idx < 784) b_if.i_pixel = pix[idx];
      else           b_if.i_pixel = 32'd0;
      b_if.i_window_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (hold) begin
        chk("big hold valid", b_if.o_window_valid, 1);
        chk("big hold window", b_if.o_window, held);
      end
      hold = b_if.o_window_valid && !b_if.i_window_ready;
      held = b_if.o_window;
      if (b_if.o_window_valid && b_if.i_window_ready) got.push_back(b_if.o_window);
      if (b_if.i_pixel_valid && b_if.o_pixel_ready) idx++;
      if (b_if.o_done) done_n++;
      @(posedge clk); #1;
      cyc++;
    end
    b_if.i_pixel_valid = 1'b0;
    chk("big done seen", done_n, 1);
    chk("big pixels taken", idx, 784);
    chk("big window count", got.size(), 676);
    for (int i = 0; i < got.size() && i < 676; i++)
      chk($sformatf("big window %0d", i), got[i], model_win(pix, 28, i));
  endtask

  initial begin
    s_if.i_start = 1'b0; s_if.i_pixel = '0; s_if.i_pixel_valid = 1'b0; s_if.i_window_ready = 1'b0;
    b_if.i_start = 1'b0; b_if.i_pixel = '0; b_if.i_pixel_valid = 1'b0; b_if.i_window_ready = 1'b0;
    for (int i = 0; i < 20; i++) small_pix.push_back(32'(i));
    repeat (2) @(posedge clk);
    #1;
    chk("reset window_valid", s_if.o_window_valid, 0);
    chk("reset pixel_ready", s_if.o_pixel_ready, 0);
    chk("reset busy", s_if.o_busy, 0);
    chk("reset done", s_if.o_done, 0);
    chk("reset window", s_if.o_window, '0);
    chk("reset big busy", b_if.o_busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_small("s1 continuous", 0, 0, 0, 0);
    run_small("s2 stall", 0, 1, 0, 0);
    run_small("s3 bubbles", 1, 0, 0, 0);
    run_small("s4 reset", 0, 0, 0, 1);
    run_small("s4 refill", 0, 0, 0, 0);
    run_small("s5 start mid", 0, 0, 1, 0);
    run_big();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
